// File: rtl/rs_syndromes_il.sv
// rs_syndromes_il: interleave-aware Reed-Solomon syndrome calculator.
// Symbols of INTERLEAVE codewords arrive round-robin. Each channel's polynomial is
// Horner-evaluated at TWO_T roots. Completed blocks are snapshotted into an output
// bank, which is drained one channel per handshake.
// Optional feature macro: RS_SYND_ZERO_FLAG_EN enables the per-channel all-zero flag.
`timescale 1ns/1ps
module rs_syndromes_il #(
    parameter int         N          = 255,
    parameter int         TWO_T      = 32,
    parameter int         INTERLEAVE = 4,
    parameter int         FCR        = 112,
    parameter int         ROOT_STEP  = 11,
    parameter logic [8:0] GF_POLY    = 9'h187
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              new_cvcdu,
    input  logic [7:0]                                        r_in,
    input  logic                                              data_valid_in,
    output logic [8*TWO_T-1:0]                                synd_out,
    output logic [((INTERLEAVE > 1) ? $clog2(INTERLEAVE) : 1)-1:0] synd_ch,
    output logic                                              synd_valid,
    input  logic                                              synd_ready,
    output logic                                              synd_zero,
    output logic                                              frame_abort,
    output logic                                              overflow
);
    localparam int CH_W  = (INTERLEAVE > 1) ? $clog2(INTERLEAVE) : 1;
    localparam int POS_W = $clog2(N + 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(INTERLEAVE - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N - 1);

    // GF(2^8) multiply; with one operand constant this reduces to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
        end
        return p;
    endfunction

    // alpha^e, evaluated only at elaboration to build the root constants.
    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 255; i++) begin
            if (i < e) r = gf_mul(r, 8'h02);
        end
        return r;
    endfunction

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    logic              r_open;
    logic [CH_W-1:0]   r_ch;
    logic [POS_W-1:0]  r_pos;
    logic              r_frame_abort;
    logic              r_overflow;
    logic [7:0]        r_acc   [INTERLEAVE][TWO_T];
    logic [7:0]        r_obank [INTERLEAVE][TWO_T];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_dch;
    logic [CH_W-1:0]   w_dch_nxt;
    logic              w_ovf;
    logic              w_accept;
    logic              w_last;
    logic              w_p0;
    logic [CH_W-1:0]   w_ch;
    logic [POS_W-1:0]  w_pos;
    logic [7:0]        w_upd  [TWO_T];
    logic [7:0]        w_snap [INTERLEAVE][TWO_T];

    // A marked symbol always restarts at k=0, so it overrides the running counters.
    assign w_accept = data_valid_in && (new_cvcdu || r_open);
    assign w_ch     = new_cvcdu ? '0 : r_ch;
    assign w_pos    = new_cvcdu ? '0 : r_pos;
    assign w_p0     = (w_pos == '0);
    assign w_last   = w_accept && (w_ch == CH_LAST) && (w_pos == POS_LAST);

    generate
        for (genvar j = 0; j < TWO_T; j++) begin : gen_root
            localparam logic [7:0] ROOT = gf_pow((ROOT_STEP * (FCR + j)) % 255);
            assign w_upd[j] = w_p0 ? r_in : (gf_mul(r_acc[w_ch][j], ROOT) ^ r_in);
        end
    endgenerate

    // Symbol counters, block-open flag and abort pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_open        <= 1'b0;
            r_ch          <= '0;
            r_pos         <= '0;
            r_frame_abort <= 1'b0;
        end else begin
            r_frame_abort <= w_accept && new_cvcdu && r_open;
            if (w_last) begin
                r_open <= 1'b0;
                r_ch   <= '0;
                r_pos  <= '0;
            end else if (w_accept) begin
                r_open <= 1'b1;
                if (w_ch == CH_LAST) begin
                    r_ch  <= '0;
                    r_pos <= w_pos + 1'b1;
                end else begin
                    r_ch  <= w_ch + 1'b1;
                    r_pos <= w_pos;
                end
            end
        end
    end

    // Horner accumulators; p=0 loads the symbol directly, so no clear is needed.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            for (int j = 0; j < TWO_T; j++) r_acc[w_ch][j] <= w_upd[j];
        end
    end

    // Snapshot view of the bank including the symbol accepted this cycle.
    always_comb begin
        for (int c = 0; c < INTERLEAVE; c++) begin
            for (int j = 0; j < TWO_T; j++) begin
                w_snap[c][j] = (CH_W'(c) == w_ch) ? w_upd[j] : r_acc[c][j];
            end
        end
    end

    // Output bank captured when the last symbol of a block is accepted.
    always_ff @(posedge clk_in) begin
        if (w_last) r_obank <= w_snap;
    end

`ifdef RS_SYND_ZERO_FLAG_EN
    logic [INTERLEAVE-1:0] r_zbank;
    logic [INTERLEAVE-1:0] w_snap_zero;

    // Per-channel all-zero reduction of the snapshot.
    always_comb begin
        for (int c = 0; c < INTERLEAVE; c++) begin
            w_snap_zero[c] = 1'b1;
            for (int j = 0; j < TWO_T; j++) begin
                if (w_snap[c][j] != 8'h00) w_snap_zero[c] = 1'b0;
            end
        end
    end

    // Zero flags travel with the output bank.
    always_ff @(posedge clk_in) begin
        if (w_last) r_zbank <= w_snap_zero;
    end

    assign synd_zero = (r_state == S_DRAIN) && r_zbank[r_dch];
`else
    assign synd_zero = 1'b0;
`endif

    // Drain state, drain channel and overflow pulse registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_dch      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dch      <= w_dch_nxt;
            r_overflow <= w_ovf;
        end
    end

    // Drain sequencing; a snapshot always restarts at channel 0.
    always_comb begin
        w_state_nxt = r_state;
        w_dch_nxt   = r_dch;
        w_ovf       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                    w_dch_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (w_last) begin
                    w_dch_nxt = '0;
                    w_ovf     = !(synd_ready && (r_dch == CH_LAST));
                end else if (synd_ready) begin
                    if (r_dch == CH_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_dch_nxt   = '0;
                    end else begin
                        w_dch_nxt = r_dch + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dch_nxt   = '0;
            end
        endcase
    end

    // Output mux: data is forced to zero whenever nothing is presented.
    always_comb begin
        synd_out = '0;
        if (r_state == S_DRAIN) begin
            for (int j = 0; j < TWO_T; j++) synd_out[8*j +: 8] = r_obank[r_dch][j];
        end
    end

    assign synd_valid  = (r_state == S_DRAIN);
    assign synd_ch     = r_dch;
    assign frame_abort = r_frame_abort;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_rs_syndromes_il.sv
// tb_rs_syndromes_il: table-driven block tests with a syndrome scoreboard, plus
// hand-written abort, overflow and mid-drain reset sequences.
`timescale 1ns/1ps
module tb_rs_syndromes_il;
    localparam int N  = 255;
    localparam int TT = 32;
    localparam int IL = 4;
    localparam int NI = N * IL;
`ifdef RS_SYND_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            new_cvcdu = 1'b0;
    logic            data_valid_in = 1'b0;
    logic            synd_ready = 1'b0;
    logic [7:0]      r_in = 8'h00;
    logic [8*TT-1:0] synd_out;
    logic [1:0]      synd_ch;
    logic            synd_valid;
    logic            synd_zero;
    logic            frame_abort;
    logic            overflow;

    always #5 clk_in = ~clk_in;

    rs_syndromes_il #(.N(N), .TWO_T(TT), .INTERLEAVE(IL), .FCR(112), .ROOT_STEP(11),
                      .GF_POLY(9'h187)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .new_cvcdu(new_cvcdu), .r_in(r_in),
        .data_valid_in(data_valid_in), .synd_out(synd_out), .synd_ch(synd_ch),
        .synd_valid(synd_valid), .synd_ready(synd_ready), .synd_zero(synd_zero),
        .frame_abort(frame_abort), .overflow(overflow));

    typedef struct {
        logic [8*TT-1:0] s;
        logic [1:0]      ch;
        logic            z;
    } exp_t;

    typedef struct {
        int         kind;     // 0 all zero, 1 single symbol, 2 random
        logic [7:0] sym;
        int         idx;
        int         max_gap;
        int         junk;     // unmarked symbols sent while idle beforehand
        int         beats;    // expected syndrome beats
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    logic [7:0] blk [NI];
    int         gexp [256];
    int         glog [256];
    int         cnt_abort = 0;
    int         cnt_ovf = 0;
    int         cnt_beats = 0;
    int         cnt_valid = 0;
    vec_t       vecs [6];

    task automatic chk(input string name, input logic [8*TT-1:0] act, input logic [8*TT-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    task automatic init_gf();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h187;
        end
    endtask

    // r * alpha^m through log/antilog tables.
    function automatic logic [7:0] gpm(input logic [7:0] r, input int m);
        if (r == 8'h00) return 8'h00;
        return 8'(gexp[(glog[r] + m) % 255]);
    endfunction

    // Direct evaluation: S_j = sum_p r_p * root_j^(N-1-p) for every channel.
    task automatic push_expected();
        exp_t       e;
        int         ej;
        logic [7:0] s;
        for (int c = 0; c < IL; c++) begin
            e.s = '0;
            for (int j = 0; j < TT; j++) begin
                ej = (11 * (112 + j)) % 255;
                s = 8'h00;
                for (int p = 0; p < N; p++) s = s ^ gpm(blk[p*IL + c], (ej * (N - 1 - p)) % 255);
                e.s[8*j +: 8] = s;
            end
            e.ch = 2'(c);
            e.z  = ZEN && (e.s == '0);
            q.push_back(e);
        end
    endtask

    task automatic fill(input int kind, input logic [7:0] sym, input int idx);
        for (int k = 0; k < NI; k++) blk[k] = (kind == 2) ? 8'($urandom) : 8'h00;
        if (kind == 1) blk[idx] = sym;
    endtask

    task automatic put_sym(input logic [7:0] s, input logic nw);
        data_valid_in = 1'b1;
        new_cvcdu     = nw;
        r_in          = s;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        new_cvcdu     = 1'b0;
        r_in          = 8'($urandom);
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_block(input int max_gap, input bit chk_lat);
        for (int k = 0; k < NI; k++) begin
            put_sym(blk[k], k == 0);
            if (k < NI - 1 && max_gap > 0) idle($urandom_range(max_gap, 1));
        end
        if (chk_lat) begin
            chk("latency_valid", synd_valid, 1);
            chk("latency_ch0", synd_ch, 0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk("drain_complete", q.size(), 0);
        chk("idle_after_drain", synd_valid, 0);
    endtask

    // Scoreboard and pulse counters, sampled away from the active edge.
    always @(negedge clk_in) begin
        exp_t e;
        if (frame_abort) cnt_abort++;
        if (overflow) cnt_ovf++;
        if (synd_valid) cnt_valid++;
        if (synd_valid && synd_ready) begin
            cnt_beats++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: ch %0d presented, none expected", synd_ch);
            end else begin
                e = q.pop_front();
                chk("synd_out", synd_out, e.s);
                chk("synd_ch", synd_ch, e.ch);
                chk("synd_zero", synd_zero, e.z);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int o0;
        int v0;
        init_gf();

        vecs[0] = '{0, 8'h00, 0,    0, 0, 4};
        vecs[1] = '{1, 8'h5A, 1018, 0, 0, 4};   // channel 2, x^0 coefficient
        vecs[2] = '{1, 8'h5A, 1018, 3, 0, 4};
        vecs[3] = '{1, 8'h01, 0,    0, 5, 4};   // channel 0, highest degree
        vecs[4] = '{2, 8'h00, 0,    0, 0, 4};
        vecs[5] = '{2, 8'h00, 0,    2, 3, 4};

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", synd_valid, 0);
        chk("rst_out", synd_out, 0);
        chk("rst_ch", synd_ch, 0);
        chk("rst_zero", synd_zero, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_overflow", overflow, 0);
        rst_in = 1'b1;
        synd_ready = 1'b1;
        idle(2);

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].kind, vecs[v].sym, vecs[v].idx);
            for (int i = 0; i < vecs[v].junk; i++) put_sym(8'($urandom_range(255, 1)), 1'b0);
            b0 = cnt_beats;
            push_expected();
            send_block(vecs[v].max_gap, 1'b1);
            wait_drain();
            chk("beat_count", cnt_beats - b0, vecs[v].beats);
            idle(3);
        end

        // Restart mid-block: only the second block may produce beats.
        fill(2, 8'h00, 0);
        put_sym(blk[0], 1'b1);
        for (int k = 1; k < 500; k++) put_sym(blk[k], 1'b0);
        fill(2, 8'h00, 0);
        push_expected();
        b0 = cnt_beats;
        put_sym(blk[0], 1'b1);
        chk("abort_pulse", frame_abort, 1);
        put_sym(blk[1], 1'b0);
        chk("abort_single", frame_abort, 0);
        for (int k = 2; k < NI; k++) put_sym(blk[k], 1'b0);
        chk("abort_latency_valid", synd_valid, 1);
        wait_drain();
        chk("abort_beats", cnt_beats - b0, 4);
        idle(3);

        // Two back-to-back blocks with no drain: the second overwrites the first.
        synd_ready = 1'b0;
        o0 = cnt_ovf;
        fill(2, 8'h00, 0);
        send_block(0, 1'b0);
        chk("ovf_none_yet", cnt_ovf - o0, 0);
        fill(2, 8'h00, 0);
        push_expected();
        send_block(0, 1'b1);
        chk("ovf_pulse", overflow, 1);
        idle(1);
        chk("ovf_single", overflow, 0);
        idle(20);
        chk("ovf_count", cnt_ovf - o0, 1);
        chk("ovf_hold_ch", synd_ch, 0);
        b0 = cnt_beats;
        synd_ready = 1'b1;
        wait_drain();
        chk("ovf_beats", cnt_beats - b0, 4);
        idle(3);

        // Asynchronous reset while channel 1 is presented.
        synd_ready = 1'b0;
        fill(2, 8'h00, 0);
        push_expected();
        send_block(0, 1'b1);
        synd_ready = 1'b1;
        idle(1);
        synd_ready = 1'b0;
        chk("drain_at_ch1", synd_ch, 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_valid", synd_valid, 0);
        chk("async_rst_out", synd_out, 0);
        q.delete();
        v0 = cnt_valid;
        idle(3);
        rst_in = 1'b1;
        synd_ready = 1'b1;
        for (int i = 0; i < 40; i++) put_sym(8'($urandom), 1'b0);
        idle(5);
        chk("no_output_after_rst", cnt_valid - v0, 0);
        fill(2, 8'h00, 0);
        push_expected();
        b0 = cnt_beats;
        send_block(1, 1'b1);
        wait_drain();
        chk("post_rst_beats", cnt_beats - b0, 4);

        chk("abort_total", cnt_abort, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
